// File: rtl/serial_len_ctrl_pkg.sv
// Shared types and constants for the serial length controller.
// State encoding is 3 bits; the bit counter width follows the length-field width.
package serial_len_ctrl_pkg;

    localparam int DEF_DW = 8;

    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_DW);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        STOP  = 3'd2,
        LOAD  = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/serial_len_ctrl_if.sv
// Serial-line input, downstream terminal count, and the length/strobe outputs.
// slave = the controller, master = whoever drives the line and models downstream.
interface serial_len_ctrl_if
    import serial_len_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic          si;
    logic          co;
    logic [DW-1:0] len;
    logic          ld;
    logic          en_cnt;
    logic          en_tri;
    logic          busy;
    logic          done;
    logic          frame_err;

    modport slave (
        input  si, co,
        output len, ld, en_cnt, en_tri, busy, done, frame_err
    );

    modport master (
        output si, co,
        input  len, ld, en_cnt, en_tri, busy, done, frame_err
    );
endinterface

// File: rtl/serial_len_ctrl_len_shreg.sv
// DW-bit LSB-first shift register: new bits enter at the MSB and move toward bit 0.
// One-cycle update when sh_en is high, holds otherwise; DW must be at least 2.
module len_shreg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sh_en,
    input  logic          sd,
    output logic [DW-1:0] q
);
    logic [DW-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (sh_en) begin
            q_d = {sd, q_q[DW-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/serial_len_ctrl.sv
// Receives start + DW LSB-first length bits + stop, then loads and runs the downstream counter.
// Outputs are Moore-decoded from the state; RUN lasts until the downstream terminal count.
module serial_len_ctrl
    import serial_len_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic              clk,
    input  logic              rst,
    serial_len_ctrl_if.slave  bus
);
    localparam int CW = (DW == DEF_DW) ? CNT_W : cnt_width(DW);
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          shift_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.si) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                // Explicit wrap keeps non-power-of-two widths correct.
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            STOP:    state_d = bus.si ? LOAD : ERR;
            LOAD:    state_d = RUN;
            RUN: begin
                if (bus.co) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign shift_en      = (state_q == SHIFT);
    assign bus.ld        = (state_q == LOAD);
    assign bus.en_cnt    = (state_q == RUN);
    assign bus.en_tri    = (state_q == RUN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.frame_err = (state_q == ERR);

    len_shreg #(
        .DW (DW)
    ) u_len_shreg (
        .clk   (clk),
        .rst   (rst),
        .sh_en (shift_en),
        .sd    (bus.si),
        .q     (bus.len)
    );
endmodule

// File: tb/tb_serial_len_ctrl.sv
// Bench for serial_len_ctrl: directed frames plus random frames against a frame-level model.
module tb_serial_len_ctrl;
    localparam int DW = 8;

    typedef struct packed {
        int       n_ld;
        int       n_run;
        int       n_done;
        int       n_err;
        int       n_excl;
        int       n_early;
        int       n_len_chg;
        logic [7:0] len_end;
        bit       finished;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ds_cnt;
    int         checks = 0;
    int         failures = 0;

    serial_len_ctrl_if #(.DW(DW)) bus ();

    serial_len_ctrl #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Downstream stage: loads ~len, counts up, flags all-ones.
    always @(posedge clk or posedge rst) begin
        if (rst)             ds_cnt <= 8'h00;
        else if (bus.ld)     ds_cnt <= ~bus.len;
        else if (bus.en_cnt) ds_cnt <= ds_cnt + 8'h01;
    end
    assign bus.co = (ds_cnt == 8'hFF);

    // Drives one frame from a negedge and observes every negedge until back in IDLE.
    task automatic run_frame(input logic [7:0] data, input logic stop, input int max_it,
                             output res_t r);
        logic [9:0] bits;
        logic [7:0] len9;
        bit         seen_end;
        bits     = {stop, data, 1'b0};
        r        = '0;
        len9     = 8'h00;
        seen_end = 1'b0;
        for (int i = 0; i < max_it; i++) begin
            if (bus.ld)        r.n_ld++;
            if (bus.en_cnt)    r.n_run++;
            if (bus.done)      r.n_done++;
            if (bus.frame_err) r.n_err++;
            if ((int'(bus.ld) + int'(bus.en_cnt) + int'(bus.done)) > 1 || bus.en_tri !== bus.en_cnt)
                r.n_excl++;
            if (i >= 1 && i <= 9 && (bus.busy !== 1'b1 || bus.ld || bus.en_cnt || bus.done || bus.frame_err))
                r.n_early++;
            if (i == 9) len9 = bus.len;
            else if (i > 9 && bus.len !== len9) r.n_len_chg++;
            if (seen_end) begin
                r.finished = (bus.busy === 1'b0);
                r.len_end  = bus.len;
                break;
            end
            if (bus.done || bus.frame_err) seen_end = 1'b1;
            bus.si = (i < 10) ? bits[i] : 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        bus.si = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.ld, bus.en_cnt, bus.en_tri, bus.done, bus.frame_err, bus.len} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0", {bus.busy, bus.ld, bus.en_cnt, bus.en_tri, bus.done, bus.frame_err, bus.len});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle_high;
        int bad = 0;
        bus.si = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy || bus.ld || bus.en_cnt || bus.en_tri || bus.done || bus.frame_err) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_high: active cycles got %0d want 0", bad);
        end
    endtask

    task automatic test_len3;
        res_t r;
        run_frame(8'h03, 1'b1, 300, r);
        checks++; if (!r.finished)        begin failures++; $display("FAIL len3_finish: got 0 want 1"); end
        checks++; if (r.len_end !== 8'h03) begin failures++; $display("FAIL len3_len: got %h want 03", r.len_end); end
        checks++; if (r.n_ld != 1)        begin failures++; $display("FAIL len3_ld: got %0d want 1", r.n_ld); end
        checks++; if (r.n_run != 4)       begin failures++; $display("FAIL len3_run: got %0d want 4", r.n_run); end
        checks++; if (r.n_done != 1 || r.n_err != 0) begin failures++; $display("FAIL len3_done: got done=%0d err=%0d want 1/0", r.n_done, r.n_err); end
        checks++; if (r.n_excl != 0)      begin failures++; $display("FAIL len3_excl: got %0d want 0", r.n_excl); end
        checks++; if (r.n_early != 0)     begin failures++; $display("FAIL len3_shift_phase: got %0d want 0", r.n_early); end
        checks++; if (r.n_len_chg != 0)   begin failures++; $display("FAIL len3_len_stable: got %0d want 0", r.n_len_chg); end
    endtask

    task automatic test_len0;
        res_t r;
        run_frame(8'h00, 1'b1, 300, r);
        checks++; if (!r.finished)   begin failures++; $display("FAIL len0_finish: got 0 want 1"); end
        checks++; if (r.n_run != 1)  begin failures++; $display("FAIL len0_run: got %0d want 1", r.n_run); end
        checks++; if (r.n_done != 1) begin failures++; $display("FAIL len0_done: got %0d want 1", r.n_done); end
    endtask

    task automatic test_frame_err;
        res_t r;
        run_frame(8'hA5, 1'b0, 300, r);
        checks++; if (!r.finished)   begin failures++; $display("FAIL ferr_idle: got 0 want 1"); end
        checks++; if (r.n_err != 1)  begin failures++; $display("FAIL ferr_pulse: got %0d want 1", r.n_err); end
        checks++; if (r.n_ld != 0 || r.n_run != 0 || r.n_done != 0) begin failures++; $display("FAIL ferr_no_strobe: got ld=%0d run=%0d done=%0d want 0/0/0", r.n_ld, r.n_run, r.n_done); end
        checks++; if (r.len_end !== 8'hA5) begin failures++; $display("FAIL ferr_len: got %h want a5", r.len_end); end
    endtask

    task automatic test_reset_mid_run;
        res_t r;
        int   bad = 0;
        run_frame(8'hFF, 1'b1, 14, r);
        checks++; if (r.n_run != 3 || r.n_done != 0) begin failures++; $display("FAIL rstrun_pre: got run=%0d done=%0d want 3/0", r.n_run, r.n_done); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.ld, bus.en_cnt, bus.en_tri, bus.done, bus.frame_err, bus.len} !== 14'd0) begin
            failures++;
            $display("FAIL rstrun_outputs: got %b want 0", {bus.busy, bus.ld, bus.en_cnt, bus.en_tri, bus.done, bus.frame_err, bus.len});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done || bus.frame_err || bus.busy) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rstrun_no_pulse: got %0d want 0", bad); end
        run_frame(8'h02, 1'b1, 300, r);
        checks++; if (!r.finished || r.n_done != 1 || r.n_run != 3 || r.len_end !== 8'h02) begin
            failures++;
            $display("FAIL rstrun_next: got fin=%0d done=%0d run=%0d len=%h want 1/1/3/02", r.finished, r.n_done, r.n_run, r.len_end);
        end
    endtask

    task automatic test_back_to_back;
        res_t r1, r2;
        run_frame(8'h01, 1'b1, 300, r1);
        run_frame(8'h02, 1'b1, 300, r2);
        checks++; if (r1.n_run != 2 || r1.n_done != 1) begin failures++; $display("FAIL b2b_first: got run=%0d done=%0d want 2/1", r1.n_run, r1.n_done); end
        checks++; if (r2.n_run != 3 || r2.n_done != 1 || r2.len_end !== 8'h02) begin
            failures++;
            $display("FAIL b2b_second: got run=%0d done=%0d len=%h want 3/1/02", r2.n_run, r2.n_done, r2.len_end);
        end
    endtask

    // Frame-level model: a good stop gives one load, N+1 run cycles and one done;
    // a bad stop gives only a single error pulse. Frames are issued back to back.
    task automatic test_random;
        res_t       r;
        logic [7:0] data;
        logic       stop;
        int         exp_run;
        for (int k = 0; k < 10; k++) begin
            data    = 8'($urandom_range(0, 255));
            stop    = ($urandom_range(0, 3) != 0);
            exp_run = stop ? int'(data) + 1 : 0;
            run_frame(data, stop, 300, r);
            checks++;
            if (!r.finished || r.len_end !== data || r.n_run != exp_run || r.n_ld != int'(stop) ||
                r.n_done != int'(stop) || r.n_err != int'(!stop) || r.n_excl != 0) begin
                failures++;
                $display("FAIL rand_%0d: data=%h stop=%0d got fin=%0d len=%h run=%0d ld=%0d done=%0d err=%0d excl=%0d want len=%h run=%0d",
                         k, data, stop, r.finished, r.len_end, r.n_run, r.n_ld, r.n_done, r.n_err, r.n_excl, data, exp_run);
            end
        end
    endtask

    initial begin
        bus.si = 1'b1;
        test_reset;
        test_idle_high;
        test_len3;
        test_len0;
        test_frame_err;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
